riscv_div_seq: RTL
==================

Name: riscv_div_seq

Overview:
- Iterative sequencer and datapath for the RV32M divide group: DIV, DIVU, REM, REMU (OPCODE_OP, funct7 0000001, funct3 100/101/110/111).
- Sits in the EX stage beside the ALU/MULT and is driven by the decoder's divide enable.
- Runs a one-bit-per-cycle restoring algorithm on operand magnitudes, then applies signs.
- Short-circuits divide-by-zero and signed overflow, and holds its result until EX accepts it.

Parameters:
DATA_WIDTH, 32, operand/result width
CNT_WIDTH, 5, iteration counter width, equal to $clog2(DATA_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  request valid
operator_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0])
op_a_i  in  DATA_WIDTH  dividend
op_b_i  in  DATA_WIDTH  divisor
kill_i  in  1  flush; abort the current operation
ex_ready_i  in  1  consumer accepts the result
ready_o  out  1  can accept a request
valid_o  out  1  result valid
result_o  out  DATA_WIDTH  quotient or remainder

Behaviour:
- Reset values: state IDLE, valid_o=0, result_o=0, ready_o=1, counter=0, internal registers 0.
- Request is accepted on any edge where enable_i && ready_o && !kill_i. Operands and operator are registered at that edge.
- ready_o=1 only in IDLE. No back-to-back acceptance: a new request is taken at the earliest one cycle after the FINISH→IDLE transition.
- FSM states IDLE, DIVIDE, FINISH:
  - IDLE→FINISH on accept if divisor==0, or if signed op with op_a=0x80000000 and op_b=0xFFFFFFFF.
  - IDLE→DIVIDE on any other accept. Counter loads DATA_WIDTH-1, remainder register clears, quotient register loads |a|.
  - DIVIDE: one restoring step per cycle. Shift {rem,quot} left by 1, trial-subtract |b|; if non-negative, keep the difference and set the quotient LSB.
  - DIVIDE→FINISH when counter==0 at the clock edge; otherwise the counter decrements.
  - FINISH: valid_o=1, result_o stable. FINISH→IDLE when ex_ready_i=1.
- Latency, with accept at edge N:
  - normal path: valid_o high for the cycle after edge N+DATA_WIDTH (33 cycles for width 32);
  - short-circuit path: valid_o high the cycle after edge N.
- Sign rules:
  - Magnitudes are used only for DIV/REM.
  - Quotient is negated when the signs of a and b differ.
  - Remainder takes the sign of the dividend.
  - DIVU/REMU operate unsigned, with no negation.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF for both DIV and DIVU; remainder = op_a.
  - Overflow: quotient 0x80000000, remainder 0.
- result_o is registered and loaded on entry to FINISH. It keeps its value after leaving FINISH and is meaningful only while valid_o=1.
- kill_i in any state: next state IDLE, valid_o=0 next cycle, in-flight result discarded. kill_i with enable_i in IDLE: kill wins, nothing is accepted.
- ex_ready_i outside FINISH is ignored.
- An asynchronous reset mid-operation returns all outputs to their reset values immediately.

Optional Feature:
- Macro RISCV_DIV_EARLY_OUT_EN.
- Defined: on accept, if |a| < |b| (unsigned magnitude compare, divisor nonzero), go directly IDLE→FINISH with quotient 0 and remainder a (signed a for REM), so valid_o asserts 1 cycle after accept.
- Not defined: the comparator is absent and such operands take the full DATA_WIDTH iterations with identical results.

Decomposition:
- Add to the shared riscv_defines package:
  - the DIV_OP_DIV/DIVU/REM/REMU 2-bit constants;
  - the div_state_t enum {IDLE, DIVIDE, FINISH}.
- One natural sub-module: riscv_div_step, a combinational single restoring iteration (inputs rem, quot, divisor; outputs next rem, next quot). The top level holds the FSM, counter, sign fix-up and short-circuits.

Test Plan:
- DIV 100/7 → 14 (0x0000000E) at 33 cycles; REM 100/7 → 2; REMU 0xFFFFFFFF/2 → 1; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); REM 7/−2 → 1.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, valid in 1 cycle.
- Backpressure: hold ex_ready_i=0 for 10 cycles in FINISH → valid_o and result_o stable, ready_o=0; release → IDLE next cycle, ready_o=1.
- kill_i at DIVIDE iteration 15 → valid_o never asserts, IDLE next cycle; a new DIV 9/3 then returns 3. kill_i with enable_i in IDLE → no accept.
- With RISCV_DIV_EARLY_OUT_EN defined: DIVU 3/10 → 0 and REMU 3/10 → 3, valid in 1 cycle. Without it, the same results arrive at 33 cycles.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RV32 definitions: divide operator codes and the divide sequencer state type.
package riscv_defines;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } div_state_t;

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract the divisor.
module riscv_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quot,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quot_next
);

  logic [DATA_WIDTH:0] rem_shift;
  logic [DATA_WIDTH:0] diff;

  // rem < divisor on entry, so the shifted value needs one extra bit at most
  assign rem_shift = {rem, quot[DATA_WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor};

  assign rem_next  = diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  assign quot_next = {quot[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

endmodule

// File: rtl/riscv_div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Optional early-out for |a| < |b| enabled by defining RISCV_DIV_EARLY_OUT_EN.
module riscv_div_seq
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [1:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  kill_i,
  input  logic                  ex_ready_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic                  is_rem_q, neg_quot_q, neg_rem_q;

  logic                  is_signed, is_rem, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic                  div_zero, overflow, early, short_path;
  logic [DATA_WIDTH-1:0] short_res, rem_nx, quot_nx, fin_res;

  assign is_signed = ~operator_i[0];
  assign is_rem    = operator_i[1];
  assign a_neg     = is_signed & op_a_i[DATA_WIDTH-1];
  assign b_neg     = is_signed & op_b_i[DATA_WIDTH-1];
  assign a_mag     = a_neg ? -op_a_i : op_a_i;
  assign b_mag     = b_neg ? -op_b_i : op_b_i;
  assign div_zero  = (op_b_i == '0);
  assign overflow  = is_signed && (op_a_i == INT_MIN) && (op_b_i == '1);

`ifdef RISCV_DIV_EARLY_OUT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  assign short_path = div_zero | overflow | early;

  always_comb begin
    short_res = '0;
    if (div_zero)      short_res = is_rem ? op_a_i : '1;
    else if (overflow) short_res = is_rem ? '0 : INT_MIN;
    else               short_res = is_rem ? op_a_i : '0;
  end

  riscv_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (dvs_q),
    .rem_next  (rem_nx),
    .quot_next (quot_nx)
  );

  // sign fix-up is applied to the last step's output so the result lands on the FINISH edge
  assign fin_res = is_rem_q ? (neg_rem_q  ? -rem_nx  : rem_nx)
                            : (neg_quot_q ? -quot_nx : quot_nx);

  assign ready_o = (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      valid_o    <= 1'b0;
      result_o   <= '0;
    end else if (kill_i) begin
      state_q <= IDLE;
      valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            is_rem_q <= is_rem;
            if (short_path) begin
              state_q  <= FINISH;
              valid_o  <= 1'b1;
              result_o <= short_res;
            end else begin
              state_q    <= DIVIDE;
              cnt_q      <= CNT_WIDTH'(DATA_WIDTH - 1);
              rem_q      <= '0;
              quot_q     <= a_mag;
              dvs_q      <= b_mag;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
            end
          end
        end
        DIVIDE: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          if (cnt_q == '0) begin
            state_q  <= FINISH;
            valid_o  <= 1'b1;
            result_o <= fin_res;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FINISH: begin
          if (ex_ready_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
